// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending-machine controller.
//
// Collects coin credit up to MAX_CREDIT and latches a pending product
// selection. It vends once credit covers the price and stock remains, then
// pays the remaining credit back as CHG_UNIT-valued pulses, one per cycle.
// It also handles cancel/refund, restock, and coin/selection rejection.
//
// Handshake: coin_valid, sel_valid, cancel and restock are one-cycle strobes
// with no back-pressure. The controller never stalls the front end.
// - A coin that cannot be taken is answered with a coin_reject pulse one
//   cycle later.
// - A refused selection is answered with a sel_reject pulse.
// - Selections made while busy are dropped silently.
//
// Ports:
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   coin_valid     coin strobe, coin_val = inserted value
//   sel_valid      selection strobe, sel = product index
//   cancel         refund request
//   restock        reload all stock counters (IDLE only)
//   product_valid  one-cycle dispense pulse, product_id = vended index
//   change_pulse   one cycle = one CHG_UNIT paid out
//   coin_reject    last coin returned, credit unchanged
//   sel_reject     selection refused (sold out / out of range)
//   credit         current credit (registered)
//   busy           high while vending or paying change
//   sold_out       bit i high when product i has no stock
//   state_dbg      current FSM state (0 IDLE, 1 COLLECT, 2 VEND, 3 CHANGE)
module vend_ctrl_param #(
  parameter int NPROD = 4,
  parameter int CW = 8,
  parameter logic [NPROD*CW-1:0] PRICE_LIST = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int CHG_UNIT = 5,
  parameter int MAX_CREDIT = 50,
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 8,
  localparam int SW = (NPROD > 1) ? $clog2(NPROD) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [CW-1:0]    coin_val,
  input  logic             sel_valid,
  input  logic [SW-1:0]    sel,
  input  logic             cancel,
  input  logic             restock,
  output logic             product_valid,
  output logic [SW-1:0]    product_id,
  output logic             change_pulse,
  output logic             coin_reject,
  output logic             sel_reject,
  output logic [CW-1:0]    credit,
  output logic             busy,
  output logic [NPROD-1:0] sold_out,
  output logic [1:0]       state_dbg
);

  localparam logic [CW:0]      MAX_C  = (CW+1)'(MAX_CREDIT);
  localparam logic [CW-1:0]    UNIT   = CW'(CHG_UNIT);
  localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] S_ONE  = STOCK_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  state_t             state;
  logic               pend_valid;
  logic [SW-1:0]      pend_sel;
  logic [STOCK_W-1:0] stock [NPROD];

  logic [CW:0]   coin_sum;
  logic          coin_fits;
  logic          sel_ok;
  logic          vend_now;
  logic          pend_acc;
  logic [CW-1:0] pend_price;
  logic [CW-1:0] credit_acc;
  logic [CW-1:0] credit_dec;

  // Sum is one bit wider than credit so a large coin cannot wrap past the cap.
  assign coin_sum   = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits  = (coin_sum <= MAX_C);
  assign sel_ok     = (32'(sel) < 32'(NPROD)) && (stock[sel] != '0);
  assign pend_price = PRICE_LIST[32'(pend_sel)*CW +: CW];
  assign vend_now   = pend_valid && (credit >= pend_price) && (stock[pend_sel] != '0);
  assign credit_acc = (coin_valid && coin_fits) ? coin_sum[CW-1:0] : credit;
  assign pend_acc   = sel_valid ? sel_ok : pend_valid;
  assign credit_dec = credit - UNIT;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      credit        <= '0;
      pend_valid    <= 1'b0;
      pend_sel      <= '0;
      for (int i = 0; i < NPROD; i++) stock[i] <= S_INIT;
      sold_out      <= {NPROD{S_INIT == '0}};
      product_valid <= 1'b0;
      product_id    <= '0;
      change_pulse  <= 1'b0;
      coin_reject   <= 1'b0;
      sel_reject    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // Pulse outputs default low; each branch raises what it needs.
      product_valid <= 1'b0;
      change_pulse  <= 1'b0;
      coin_reject   <= 1'b0;
      sel_reject    <= 1'b0;
      busy          <= 1'b0;
      case (state)
        S_IDLE, S_COLLECT: begin
          if (restock && state == S_IDLE) begin
            for (int i = 0; i < NPROD; i++) stock[i] <= S_INIT;
            sold_out <= {NPROD{S_INIT == '0}};
          end
          if (cancel) begin
            // Cancel wins over everything: a coin in the same cycle bounces.
            pend_valid  <= 1'b0;
            coin_reject <= coin_valid;
            if (credit >= UNIT) begin
              state        <= S_CHANGE;
              change_pulse <= 1'b1;
              busy         <= 1'b1;
            end else begin
              state  <= S_IDLE;
              credit <= '0;
            end
          end else if (state == S_COLLECT && vend_now) begin
            // The machine is committed to the vend; a coin arriving on this
            // edge is returned and a selection is dropped.
            credit                <= credit - pend_price;
            stock[pend_sel]       <= stock[pend_sel] - S_ONE;
            sold_out[pend_sel]    <= (stock[pend_sel] == S_ONE);
            pend_valid            <= 1'b0;
            state                 <= S_VEND;
            product_valid         <= 1'b1;
            product_id            <= pend_sel;
            busy                  <= 1'b1;
            coin_reject           <= coin_valid;
          end else begin
            credit      <= credit_acc;
            coin_reject <= coin_valid && !coin_fits;
            if (sel_valid) begin
              pend_valid <= sel_ok;
              sel_reject <= !sel_ok;
              if (sel_ok) pend_sel <= sel;
            end
            state <= (credit_acc != '0 || pend_acc) ? S_COLLECT : S_IDLE;
          end
        end
        S_VEND: begin
          coin_reject <= coin_valid;
          if (credit >= UNIT) begin
            state        <= S_CHANGE;
            change_pulse <= 1'b1;
            busy         <= 1'b1;
          end else begin
            state  <= S_IDLE;
            credit <= '0;
          end
        end
        S_CHANGE: begin
          coin_reject <= coin_valid;
          // Stay while at least one more whole unit remains after this pulse.
          if (credit_dec >= UNIT) begin
            credit       <= credit_dec;
            change_pulse <= 1'b1;
            busy         <= 1'b1;
          end else begin
            credit <= '0;
            state  <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          credit <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised vending-machine controller, the successor to the fixed four-item, fixed-coin vending FSM. It accumulates coin credit of arbitrary denomination up to a cap and latches a product selection. When credit covers the price and stock is available, it vends and then pays change serially as unit pulses. It sits between the coin acceptor/keypad front end and the dispense/payout actuators, and adds per-product stock tracking, cancel/refund, pending selection and coin rejection.

## Interface
- NPROD, 4: number of products; select width SW = $clog2(NPROD) (min 1).
- CW, 8: credit/price/coin value width.
- PRICE_LIST, {8'd20,8'd15,8'd10,8'd5}: packed NPROD*CW prices; product i occupies bits [i*CW +: CW].
- CHG_UNIT, 5: value of one change pulse. All prices and coins are multiples of it.
- MAX_CREDIT, 50: credit cap.
- STOCK_W, 4: per-product stock counter width.
- STOCK_INIT, 8: stock value loaded at reset and on restock.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- coin_valid  in  1  one-cycle strobe: coin_val is inserted.
- coin_val  in  CW  inserted coin value.
- sel_valid  in  1  one-cycle strobe: sel is pressed.
- sel  in  SW  product index.
- cancel  in  1  request refund of credit.
- restock  in  1  reload all stock counters.
- product_valid  out  1  one-cycle dispense pulse.
- product_id  out  SW  dispensed index, valid with product_valid.
- change_pulse  out  1  one cycle = one CHG_UNIT paid out.
- coin_reject  out  1  one-cycle pulse: the last coin is returned, credit unchanged.
- sel_reject  out  1  one-cycle pulse: selection refused (sold out or sel >= NPROD).
- credit  out  CW  current credit (registered).
- busy  out  1  high in VEND and CHANGE.
- sold_out  out  NPROD  bit i high when stock[i] == 0.

## Operation
- States: IDLE (credit 0, no pending), COLLECT (credit > 0 or selection pending), VEND, CHANGE. Unused encodings go to IDLE with credit cleared.
- Coin accept (IDLE/COLLECT, no cancel): compute credit + coin_val at CW+1 bits.
  - If the sum is <= MAX_CREDIT, credit takes the sum.
  - Otherwise coin_reject pulses and credit is unchanged.
  - Coins in VEND/CHANGE are always rejected.
- Selection (IDLE/COLLECT):
  - sel_valid latches sel as pending, replacing any earlier pending selection.
  - If sel >= NPROD or stock[sel] == 0, sel_reject pulses and pending is cleared.
  - sel_valid is ignored in VEND/CHANGE.
- Vend condition, checked every cycle in COLLECT: pending valid, credit >= price[pending], stock > 0.
  - On the vend edge: credit -= price, stock[pending] -= 1, pending cleared, state goes to VEND.
- VEND: lasts one cycle. product_valid = 1 and product_id = vended index. Next state is CHANGE if credit >= CHG_UNIT, else IDLE with credit cleared.
- CHANGE: change_pulse = 1 each cycle and credit -= CHG_UNIT at each edge.
  - Go to IDLE when the remaining credit is < CHG_UNIT; any residue is cleared to 0.
- cancel in IDLE/COLLECT: pending cleared. Go to CHANGE if credit >= CHG_UNIT, else IDLE. cancel is ignored in VEND/CHANGE.
- Priority in the same cycle: cancel > coin > sel.
  - With cancel, a coin is rejected and sel is ignored.
  - Coin and sel together: both are taken, and the vend check uses the updated credit on the following cycle.
- restock: honoured only in IDLE; all stock counters set to STOCK_INIT. Ignored elsewhere.
- Stock never decrements below 0; credit never exceeds MAX_CREDIT.

## Timing
- All outputs registered.
- Reset values: state IDLE, credit 0, pending cleared, stock all STOCK_INIT, sold_out 0 (when STOCK_INIT > 0), and product_valid, product_id, change_pulse, coin_reject, sel_reject, busy all 0.
- Coin sampled at edge t: credit updated, or coin_reject high, in cycle t+1.
- Vend latency:
  - Condition true in cycle t (COLLECT), so the state is VEND at edge t.
  - product_valid is high in cycle t+1.
  - The first change_pulse is in cycle t+2.
  - N change pulses occupy consecutive cycles; busy drops in the cycle after the last pulse.
- Pending selection with sufficient credit already present: sel at edge t, state COLLECT in cycle t+1 with the condition true, product_valid in cycle t+2.
- Cancel at edge t: first change_pulse in cycle t+1.
- rst_n low at any edge, including mid-CHANGE: all state returns to reset values next cycle. Unpaid credit is discarded and pulses stop immediately.

## Test plan
- Reset, coin 5, sel 0 -> product_valid with product_id = 0 two cycles after sel; no change_pulse; credit 0; stock[0] = 7.
- Coin 20, sel 1 (price 10) -> one product_valid, then exactly 2 consecutive change_pulse; credit returns to 0; busy low afterwards.
- sel 2 (price 15) first, then coin 10, then coin 5 -> no vend after the 10; product_valid (id 2) two cycles after the second coin sample; no change.
- Coin 20, coin 20, coin 10 (credit 50), then coin 5 -> coin_reject pulse, credit stays 50; cancel -> exactly 10 change_pulse, no product_valid.
- STOCK_INIT = 1: vend product 3 once, then sel 3 -> sel_reject and sold_out[3] = 1; restock in IDLE -> sold_out[3] = 0.
- Coin 50, sel 0, assert rst_n = 0 on the 3rd change_pulse -> next cycle change_pulse = 0, credit 0, state IDLE, all stock = STOCK_INIT.
